// File: rtl/dsc_byp_pkg.sv
// dsc_byp_pkg: bypass-in descriptor structs, raw-descriptor bit positions and
// the decode helpers shared by the H2C descriptor-bypass buffer.
package dsc_byp_pkg;

    // Only the low 192 bits of the raw bypass-out descriptor carry fields.
    localparam int DSC_MIN_W = 192;
    // Width of the qid field in the bypass-in structs; QID_W must not exceed it.
    localparam int DSC_QID_W = 11;
    localparam int ADDR_W    = 64;

    // MM raw-descriptor layout
    localparam int MM_RADR_LSB = 0;
    localparam int MM_LEN_LSB  = 64;
    localparam int MM_LEN_W    = 28;
    localparam int MM_EOP_BIT  = 94;
    localparam int MM_WADR_LSB = 128;

    // ST raw-descriptor layout
    localparam int ST_LEN_LSB  = 32;
    localparam int ST_LEN_W    = 16;
    localparam int ST_SOP_BIT  = 48;
    localparam int ST_EOP_BIT  = 49;
    localparam int ST_ADDR_LSB = 64;

    // Sideband fields copied unchanged into either path
    typedef struct packed {
        logic [DSC_QID_W-1:0] qid;
        logic                 error;
        logic [7:0]           func;
        logic [15:0]          cidx;
        logic [2:0]           port_id;
    } byp_side_t;

    typedef struct packed {
        logic [ADDR_W-1:0]    radr;
        logic [ADDR_W-1:0]    wadr;
        logic [MM_LEN_W-1:0]  len;
        logic                 mrkr_req;
        logic                 sdi;
        logic [DSC_QID_W-1:0] qid;
        logic                 error;
        logic [7:0]           func;
        logic [15:0]          cidx;
        logic [2:0]           port_id;
        logic                 no_dma;
    } mm_dsc_t;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [ST_LEN_W-1:0]  len;
        logic                 eop;
        logic                 sop;
        logic                 mrkr_req;
        logic                 sdi;
        logic [DSC_QID_W-1:0] qid;
        logic                 error;
        logic [7:0]           func;
        logic [15:0]          cidx;
        logic [2:0]           port_id;
        logic                 no_dma;
    } st_dsc_t;

    // Decode a raw descriptor into an MM bypass-in entry
    function automatic mm_dsc_t decode_mm(input logic [DSC_MIN_W-1:0] dsc,
                                          input byp_side_t            side,
                                          input logic                 mrkr_req,
                                          input logic                 sdi_on_eop);
        mm_dsc_t d;
        d.radr     = dsc[MM_RADR_LSB +: ADDR_W];
        d.wadr     = dsc[MM_WADR_LSB +: ADDR_W];
        d.len      = dsc[MM_LEN_LSB +: MM_LEN_W];
        d.mrkr_req = mrkr_req;
        d.sdi      = sdi_on_eop ? dsc[MM_EOP_BIT] : 1'b1;
        d.qid      = side.qid;
        d.error    = side.error;
        d.func     = side.func;
        d.cidx     = side.cidx;
        d.port_id  = side.port_id;
        d.no_dma   = 1'b0;
        return d;
    endfunction

    // Decode a raw descriptor into an ST bypass-in entry
    function automatic st_dsc_t decode_st(input logic [DSC_MIN_W-1:0] dsc,
                                          input byp_side_t            side,
                                          input logic                 mrkr_req);
        st_dsc_t d;
        d.addr     = dsc[ST_ADDR_LSB +: ADDR_W];
        d.len      = dsc[ST_LEN_LSB +: ST_LEN_W];
        d.eop      = dsc[ST_EOP_BIT];
        d.sop      = dsc[ST_SOP_BIT];
        d.mrkr_req = mrkr_req;
        d.sdi      = 1'b1;
        d.qid      = side.qid;
        d.error    = side.error;
        d.func     = side.func;
        d.cidx     = side.cidx;
        d.port_id  = side.port_id;
        d.no_dma   = 1'b0;
        return d;
    endfunction

    // Saturating 32-bit increment for the statistics counters
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/dsc_byp_fifo.sv
// dsc_byp_fifo: first-word-fall-through FIFO of an arbitrary packed type.
// Pointers carry an extra wrap bit so level = wptr - rptr covers 0..DEPTH.
// The full flag is registered, so a pop never opens space in the same cycle.
module dsc_byp_fifo #(
    parameter type T         = logic [7:0],
    parameter int  DEPTH     = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  T            din,
    output logic        full,
    input  logic        pop,
    output T            dout,
    output logic        empty,
    output logic [AW:0] level
);

    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    T            mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] level_nxt;
    logic        full_q;
    logic        wr_en;
    logic        rd_en;

    assign empty     = (wptr == rptr);
    assign full      = full_q;
    assign wr_en     = push & ~full_q;
    assign rd_en     = pop & ~empty;
    assign level     = wptr - rptr;
    assign level_nxt = level + (wr_en ? PTR_ONE : '0) - (rd_en ? PTR_ONE : '0);

    // Pointer and full-flag state
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of process evaluation order.
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            full_q <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + PTR_ONE;
            if (rd_en) rptr <= rptr + PTR_ONE;
            full_q <= (level_nxt == FULL_LVL);
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; stale entries are never visible
        // because the read side masks the head with the empty flag.
        if (wr_en) mem[wptr[AW-1:0]] <= din;
    end

    // Head presentation: zero while empty, otherwise the oldest entry
    always_comb begin
        // NOTE: default first so no path leaves dout unassigned (no latch).
        dout = '0;
        if (!empty) dout = mem[rptr[AW-1:0]];
    end

endmodule

// File: rtl/dsc_byp_h2c_buf.sv
// dsc_byp_h2c_buf: buffered H2C descriptor-bypass loopback. Decodes QDMA
// bypass-out descriptors into MM or ST bypass-in entries, each path queued in
// its own FIFO, and turns marker responses into one-cycle pulses.
// Optional macro DSC_BYP_STATS_EN adds the h2c_byp_stats counter port.
module dsc_byp_h2c_buf
    import dsc_byp_pkg::*;
#(
    parameter int  DSC_W      = 256,
    parameter int  QID_W      = 11,
    parameter int  FIFO_DEPTH = 8,
    parameter int  SDI_ON_EOP = 1,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              h2c_dsc_bypass,
    input  logic              h2c_mm_marker_req,
    input  logic              h2c_st_marker_req,
    output logic              h2c_mm_marker_rsp,
    output logic              h2c_st_marker_rsp,
    input  logic [DSC_W-1:0]  h2c_byp_out_dsc,
    input  logic              h2c_byp_out_mrkr_rsp,
    input  logic              h2c_byp_out_st_mm,
    input  logic              h2c_byp_out_error,
    input  logic [QID_W-1:0]  h2c_byp_out_qid,
    input  logic [7:0]        h2c_byp_out_func,
    input  logic [15:0]       h2c_byp_out_cidx,
    input  logic [2:0]        h2c_byp_out_port_id,
    input  logic              h2c_byp_out_vld,
    output logic              h2c_byp_out_rdy,
    output mm_dsc_t           h2c_byp_in_mm,
    output logic              h2c_byp_in_mm_vld,
    input  logic              h2c_byp_in_mm_rdy,
    output st_dsc_t           h2c_byp_in_st,
    output logic              h2c_byp_in_st_vld,
    input  logic              h2c_byp_in_st_rdy,
`ifdef DSC_BYP_STATS_EN
    output logic [3:0][31:0]  h2c_byp_stats,
`endif
    output logic [LVL_W-1:0]  mm_level,
    output logic [LVL_W-1:0]  st_level
);

    logic      accept;
    logic      is_mrkr;
    logic      is_mm;
    logic      mm_full;
    logic      st_full;
    logic      mm_empty;
    logic      st_empty;
    logic      mm_push;
    logic      st_push;
    logic      mm_pop;
    logic      st_pop;
    byp_side_t side;
    mm_dsc_t   mm_wr;
    st_dsc_t   st_wr;

    assign is_mrkr = h2c_byp_out_mrkr_rsp;
    assign is_mm   = h2c_byp_out_st_mm;

    // Marker responses and bypass-off traffic are always taken; descriptors
    // otherwise wait for space in the FIFO selected by st_mm.
    assign h2c_byp_out_rdy = is_mrkr | ~h2c_dsc_bypass | (is_mm ? ~mm_full : ~st_full);
    assign accept          = h2c_byp_out_vld & h2c_byp_out_rdy;

    assign mm_push = accept & ~is_mrkr & h2c_dsc_bypass & is_mm;
    assign st_push = accept & ~is_mrkr & h2c_dsc_bypass & ~is_mm;

    assign side.qid     = DSC_QID_W'(h2c_byp_out_qid);
    assign side.error   = h2c_byp_out_error;
    assign side.func    = h2c_byp_out_func;
    assign side.cidx    = h2c_byp_out_cidx;
    assign side.port_id = h2c_byp_out_port_id;

    assign mm_wr = decode_mm(h2c_byp_out_dsc[DSC_MIN_W-1:0], side,
                             h2c_mm_marker_req, SDI_ON_EOP != 0);
    assign st_wr = decode_st(h2c_byp_out_dsc[DSC_MIN_W-1:0], side,
                             h2c_st_marker_req);

    // Bits above the decoded range are reserved and ignored.
    generate
        if (DSC_W > DSC_MIN_W) begin : g_dsc_hi
            logic unused_dsc_hi;
            assign unused_dsc_hi = ^h2c_byp_out_dsc[DSC_W-1:DSC_MIN_W];
        end
    endgenerate

    dsc_byp_fifo #(
        .T     (mm_dsc_t),
        .DEPTH (FIFO_DEPTH)
    ) u_mm_fifo (
        .clk   (axi_aclk),
        .rst_n (axi_aresetn),
        .push  (mm_push),
        .din   (mm_wr),
        .full  (mm_full),
        .pop   (mm_pop),
        .dout  (h2c_byp_in_mm),
        .empty (mm_empty),
        .level (mm_level)
    );

    dsc_byp_fifo #(
        .T     (st_dsc_t),
        .DEPTH (FIFO_DEPTH)
    ) u_st_fifo (
        .clk   (axi_aclk),
        .rst_n (axi_aresetn),
        .push  (st_push),
        .din   (st_wr),
        .full  (st_full),
        .pop   (st_pop),
        .dout  (h2c_byp_in_st),
        .empty (st_empty),
        .level (st_level)
    );

    assign h2c_byp_in_mm_vld = ~mm_empty;
    assign h2c_byp_in_st_vld = ~st_empty;
    assign mm_pop            = h2c_byp_in_mm_vld & h2c_byp_in_mm_rdy;
    assign st_pop            = h2c_byp_in_st_vld & h2c_byp_in_st_rdy;

    // One-cycle marker-response pulse on the cycle after acceptance
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            h2c_mm_marker_rsp <= 1'b0;
            h2c_st_marker_rsp <= 1'b0;
        end else begin
            h2c_mm_marker_rsp <= accept & is_mrkr & is_mm;
            h2c_st_marker_rsp <= accept & is_mrkr & ~is_mm;
        end
    end

`ifdef DSC_BYP_STATS_EN
    logic [3:0][31:0] stats_q;
    logic             drop;
    logic             mrkr_seen;

    assign drop      = accept & ~is_mrkr & ~h2c_dsc_bypass;
    assign mrkr_seen = accept & is_mrkr;

    // Saturating counters: MM pops, ST pops, drops, marker responses
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            stats_q <= '0;
        end else begin
            stats_q[0] <= sat_inc(stats_q[0], mm_pop);
            stats_q[1] <= sat_inc(stats_q[1], st_pop);
            stats_q[2] <= sat_inc(stats_q[2], drop);
            stats_q[3] <= sat_inc(stats_q[3], mrkr_seen);
        end
    end

    assign h2c_byp_stats = stats_q;
`endif

endmodule

// File: tb/tb_dsc_byp_h2c_buf.sv
// Directed bench for dsc_byp_h2c_buf (default parameters).
// Inputs change on the falling edge; outputs are sampled there or 1 ns later.
`timescale 1ns/1ps
module tb_dsc_byp_h2c_buf;
    import dsc_byp_pkg::*;

    localparam int DSC_W      = 256;
    localparam int QID_W      = 11;
    localparam int FIFO_DEPTH = 8;
    localparam int LVL_W      = 4;

    logic              axi_aclk = 1'b0;
    logic              axi_aresetn;
    logic              h2c_dsc_bypass;
    logic              h2c_mm_marker_req;
    logic              h2c_st_marker_req;
    logic              h2c_mm_marker_rsp;
    logic              h2c_st_marker_rsp;
    logic [DSC_W-1:0]  h2c_byp_out_dsc;
    logic              h2c_byp_out_mrkr_rsp;
    logic              h2c_byp_out_st_mm;
    logic              h2c_byp_out_error;
    logic [QID_W-1:0]  h2c_byp_out_qid;
    logic [7:0]        h2c_byp_out_func;
    logic [15:0]       h2c_byp_out_cidx;
    logic [2:0]        h2c_byp_out_port_id;
    logic              h2c_byp_out_vld;
    logic              h2c_byp_out_rdy;
    mm_dsc_t           h2c_byp_in_mm;
    logic              h2c_byp_in_mm_vld;
    logic              h2c_byp_in_mm_rdy;
    st_dsc_t           h2c_byp_in_st;
    logic              h2c_byp_in_st_vld;
    logic              h2c_byp_in_st_rdy;
`ifdef DSC_BYP_STATS_EN
    logic [3:0][31:0]  h2c_byp_stats;
`endif
    logic [LVL_W-1:0]  mm_level;
    logic [LVL_W-1:0]  st_level;

    int checks = 0;
    int errors = 0;

    always #5 axi_aclk = ~axi_aclk;

    dsc_byp_h2c_buf #(
        .DSC_W      (DSC_W),
        .QID_W      (QID_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SDI_ON_EOP (1)
    ) dut (
        .axi_aclk             (axi_aclk),
        .axi_aresetn          (axi_aresetn),
        .h2c_dsc_bypass       (h2c_dsc_bypass),
        .h2c_mm_marker_req    (h2c_mm_marker_req),
        .h2c_st_marker_req    (h2c_st_marker_req),
        .h2c_mm_marker_rsp    (h2c_mm_marker_rsp),
        .h2c_st_marker_rsp    (h2c_st_marker_rsp),
        .h2c_byp_out_dsc      (h2c_byp_out_dsc),
        .h2c_byp_out_mrkr_rsp (h2c_byp_out_mrkr_rsp),
        .h2c_byp_out_st_mm    (h2c_byp_out_st_mm),
        .h2c_byp_out_error    (h2c_byp_out_error),
        .h2c_byp_out_qid      (h2c_byp_out_qid),
        .h2c_byp_out_func     (h2c_byp_out_func),
        .h2c_byp_out_cidx     (h2c_byp_out_cidx),
        .h2c_byp_out_port_id  (h2c_byp_out_port_id),
        .h2c_byp_out_vld      (h2c_byp_out_vld),
        .h2c_byp_out_rdy      (h2c_byp_out_rdy),
        .h2c_byp_in_mm        (h2c_byp_in_mm),
        .h2c_byp_in_mm_vld    (h2c_byp_in_mm_vld),
        .h2c_byp_in_mm_rdy    (h2c_byp_in_mm_rdy),
        .h2c_byp_in_st        (h2c_byp_in_st),
        .h2c_byp_in_st_vld    (h2c_byp_in_st_vld),
        .h2c_byp_in_st_rdy    (h2c_byp_in_st_rdy),
`ifdef DSC_BYP_STATS_EN
        .h2c_byp_stats        (h2c_byp_stats),
`endif
        .mm_level             (mm_level),
        .st_level             (st_level)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raw MM descriptor: radr[63:0], len[91:64], eop[94], wadr[191:128]
    function automatic logic [DSC_W-1:0] mk_mm(input logic [63:0] radr, input logic [27:0] len,
                                               input logic [63:0] wadr, input logic eop);
        logic [DSC_W-1:0] d;
        d          = '0;
        d[63:0]    = radr;
        d[91:64]   = len;
        d[94]      = eop;
        d[191:128] = wadr;
        return d;
    endfunction

    // Raw ST descriptor: len[47:32], sop[48], eop[49], addr[127:64]
    function automatic logic [DSC_W-1:0] mk_st(input logic [63:0] addr, input logic [15:0] len,
                                               input logic sop, input logic eop);
        logic [DSC_W-1:0] d;
        d          = '0;
        d[47:32]   = len;
        d[48]      = sop;
        d[49]      = eop;
        d[127:64]  = addr;
        return d;
    endfunction

    initial begin
        axi_aresetn          = 1'b0;
        h2c_dsc_bypass       = 1'b0;
        h2c_mm_marker_req    = 1'b0;
        h2c_st_marker_req    = 1'b0;
        h2c_byp_out_dsc      = '0;
        h2c_byp_out_mrkr_rsp = 1'b0;
        h2c_byp_out_st_mm    = 1'b0;
        h2c_byp_out_error    = 1'b0;
        h2c_byp_out_qid      = '0;
        h2c_byp_out_func     = '0;
        h2c_byp_out_cidx     = '0;
        h2c_byp_out_port_id  = '0;
        h2c_byp_out_vld      = 1'b0;
        h2c_byp_in_mm_rdy    = 1'b0;
        h2c_byp_in_st_rdy    = 1'b0;

        // ---- reset state ----
        repeat (2) @(negedge axi_aclk);
        check("rst_out_rdy", h2c_byp_out_rdy, 1);
        check("rst_mm_vld", h2c_byp_in_mm_vld, 0);
        check("rst_st_vld", h2c_byp_in_st_vld, 0);
        check("rst_mm_level", mm_level, 0);
        check("rst_st_level", st_level, 0);
        check("rst_mm_mrsp", h2c_mm_marker_rsp, 0);
        check("rst_st_mrsp", h2c_st_marker_rsp, 0);
        check("rst_mm_data", h2c_byp_in_mm, '0);
        check("rst_st_data", h2c_byp_in_st, '0);
        axi_aresetn    = 1'b1;
        h2c_dsc_bypass = 1'b1;
        @(negedge axi_aclk);

        // ---- single MM descriptor, 1-cycle latency ----
        h2c_byp_out_st_mm   = 1'b1;
        h2c_byp_out_dsc     = mk_mm(64'h1000, 28'h40, 64'h2000, 1'b1);
        h2c_byp_out_qid     = 11'd5;
        h2c_byp_out_func    = 8'h3C;
        h2c_byp_out_cidx    = 16'h0012;
        h2c_byp_out_port_id = 3'd2;
        h2c_byp_out_vld     = 1'b1;
        #1;
        check("mm1_out_rdy", h2c_byp_out_rdy, 1);
        check("mm1_vld_early", h2c_byp_in_mm_vld, 0);
        @(negedge axi_aclk);
        h2c_byp_out_vld = 1'b0;
        check("mm1_vld", h2c_byp_in_mm_vld, 1);
        check("mm1_st_vld", h2c_byp_in_st_vld, 0);
        check("mm1_radr", h2c_byp_in_mm.radr, 64'h1000);
        check("mm1_wadr", h2c_byp_in_mm.wadr, 64'h2000);
        check("mm1_len", h2c_byp_in_mm.len, 28'h40);
        check("mm1_sdi", h2c_byp_in_mm.sdi, 1);
        check("mm1_qid", h2c_byp_in_mm.qid, 5);
        check("mm1_func", h2c_byp_in_mm.func, 8'h3C);
        check("mm1_cidx", h2c_byp_in_mm.cidx, 16'h0012);
        check("mm1_port", h2c_byp_in_mm.port_id, 2);
        check("mm1_mrkr_req", h2c_byp_in_mm.mrkr_req, 0);
        check("mm1_no_dma", h2c_byp_in_mm.no_dma, 0);
        check("mm1_level", mm_level, 1);
        h2c_byp_in_mm_rdy = 1'b1;
        @(negedge axi_aclk);
        h2c_byp_in_mm_rdy = 1'b0;
        check("mm1_popped_vld", h2c_byp_in_mm_vld, 0);
        check("mm1_popped_level", mm_level, 0);

        // ---- fill MM FIFO with mm_rdy held low: entry i has radr i*0x100, len i, eop i[0] ----
        for (int i = 1; i <= 8; i++) begin
            h2c_byp_out_dsc = mk_mm(64'(i) * 64'h100, 28'(i), 64'h8000 + 64'(i), i[0]);
            h2c_byp_out_qid = 11'(i);
            h2c_byp_out_vld = 1'b1;
            #1;
            check("fill_out_rdy", h2c_byp_out_rdy, 1);
            @(negedge axi_aclk);
        end
        check("fill_level", mm_level, 8);
        h2c_byp_out_dsc = mk_mm(64'h900, 28'd9, 64'h8009, 1'b1);
        h2c_byp_out_qid = 11'd9;
        #1;
        check("full_out_rdy", h2c_byp_out_rdy, 0);
        @(negedge axi_aclk);
        check("full_level_hold", mm_level, 8);
        check("full_head_stable", h2c_byp_in_mm.radr, 64'h100);

        // ---- ST traffic still flows while MM is full ----
        h2c_byp_out_st_mm = 1'b0;
        h2c_byp_out_dsc   = mk_st(64'hA000, 16'h100, 1'b1, 1'b1);
        h2c_byp_out_qid   = 11'h21;
        h2c_st_marker_req = 1'b1;
        #1;
        check("st1_out_rdy", h2c_byp_out_rdy, 1);
        @(negedge axi_aclk);
        h2c_st_marker_req = 1'b0;
        check("st1_vld", h2c_byp_in_st_vld, 1);
        check("st1_addr", h2c_byp_in_st.addr, 64'hA000);
        check("st1_len", h2c_byp_in_st.len, 16'h100);
        check("st1_sop", h2c_byp_in_st.sop, 1);
        check("st1_eop", h2c_byp_in_st.eop, 1);
        check("st1_mrkr_req", h2c_byp_in_st.mrkr_req, 1);
        check("st1_sdi", h2c_byp_in_st.sdi, 1);
        check("st1_qid", h2c_byp_in_st.qid, 11'h21);
        check("st1_mm_level", mm_level, 8);
        h2c_byp_out_dsc = mk_st(64'hB000, 16'h20, 1'b0, 1'b0);
        h2c_byp_out_qid = 11'h22;
        @(negedge axi_aclk);
        h2c_byp_out_vld = 1'b0;
        check("st2_level", st_level, 2);
        check("st2_head_stable", h2c_byp_in_st.addr, 64'hA000);
        h2c_byp_in_st_rdy = 1'b1;
        @(negedge axi_aclk);
        check("st2_addr", h2c_byp_in_st.addr, 64'hB000);
        check("st2_mrkr_req", h2c_byp_in_st.mrkr_req, 0);
        check("st2_sop", h2c_byp_in_st.sop, 0);
        check("st2_level_after_pop", st_level, 1);
        @(negedge axi_aclk);
        h2c_byp_in_st_rdy = 1'b0;
        check("st_drained_vld", h2c_byp_in_st_vld, 0);

        // ---- drain MM; 9th descriptor blocked while full even with a pop ----
        h2c_byp_out_st_mm = 1'b1;
        h2c_byp_out_dsc   = mk_mm(64'h900, 28'd9, 64'h8009, 1'b1);
        h2c_byp_out_qid   = 11'd9;
        h2c_byp_out_vld   = 1'b1;
        h2c_byp_in_mm_rdy = 1'b1;
        #1;
        check("full_pop_out_rdy", h2c_byp_out_rdy, 0);
        check("drain1_radr", h2c_byp_in_mm.radr, 64'h100);
        check("drain1_sdi", h2c_byp_in_mm.sdi, 1);
        @(negedge axi_aclk);
        check("drain2_level", mm_level, 7);
        check("drain2_out_rdy", h2c_byp_out_rdy, 1);
        check("drain2_radr", h2c_byp_in_mm.radr, 64'h200);
        check("drain2_sdi", h2c_byp_in_mm.sdi, 0);
        check("drain2_qid", h2c_byp_in_mm.qid, 2);
        @(negedge axi_aclk);
        h2c_byp_out_vld = 1'b0;
        check("pushpop_level", mm_level, 7);
        for (int i = 3; i <= 9; i++) begin
            check("drain_radr", h2c_byp_in_mm.radr, 64'(i) * 64'h100);
            check("drain_len", h2c_byp_in_mm.len, 28'(i));
            @(negedge axi_aclk);
        end
        h2c_byp_in_mm_rdy = 1'b0;
        check("drain_done_vld", h2c_byp_in_mm_vld, 0);
        check("drain_done_level", mm_level, 0);

        // ---- marker responses ----
        h2c_byp_out_st_mm    = 1'b0;
        h2c_byp_out_mrkr_rsp = 1'b1;
        h2c_byp_out_dsc      = mk_st(64'hDEAD, 16'h10, 1'b1, 1'b1);
        h2c_byp_out_vld      = 1'b1;
        #1;
        check("mrkr_out_rdy", h2c_byp_out_rdy, 1);
        @(negedge axi_aclk);
        h2c_byp_out_vld = 1'b0;
        check("st_mrsp_pulse", h2c_st_marker_rsp, 1);
        check("st_mrsp_mm_quiet", h2c_mm_marker_rsp, 0);
        check("st_mrsp_no_enq", st_level, 0);
        check("st_mrsp_no_vld", h2c_byp_in_st_vld, 0);
        @(negedge axi_aclk);
        check("st_mrsp_one_cycle", h2c_st_marker_rsp, 0);
        h2c_byp_out_st_mm = 1'b1;
        h2c_byp_out_vld   = 1'b1;
        @(negedge axi_aclk);
        h2c_byp_out_vld      = 1'b0;
        h2c_byp_out_mrkr_rsp = 1'b0;
        check("mm_mrsp_pulse", h2c_mm_marker_rsp, 1);
        check("mm_mrsp_st_quiet", h2c_st_marker_rsp, 0);
        check("mm_mrsp_no_enq", mm_level, 0);
        @(negedge axi_aclk);
        check("mm_mrsp_one_cycle", h2c_mm_marker_rsp, 0);

        // ---- bypass off with 3 ST entries queued ----
        h2c_byp_out_st_mm = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            h2c_byp_out_dsc = mk_st(64'hC000 + 64'(i) * 64'h100, 16'h40, 1'b1, 1'b1);
            h2c_byp_out_vld = 1'b1;
            @(negedge axi_aclk);
        end
        check("byp_off_pre_level", st_level, 3);
        h2c_dsc_bypass  = 1'b0;
        h2c_byp_out_dsc = mk_st(64'hDD00, 16'h40, 1'b1, 1'b1);
        #1;
        check("byp_off_out_rdy", h2c_byp_out_rdy, 1);
        @(negedge axi_aclk);
        h2c_byp_out_vld = 1'b0;
        check("byp_off_dropped", st_level, 3);
        h2c_byp_in_st_rdy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check("byp_off_drain_addr", h2c_byp_in_st.addr, 64'hC000 + 64'(i) * 64'h100);
            @(negedge axi_aclk);
        end
        h2c_byp_in_st_rdy = 1'b0;
        check("byp_off_drained", h2c_byp_in_st_vld, 0);
`ifdef DSC_BYP_STATS_EN
        check("stats_mm_pops", h2c_byp_stats[0], 10);
        check("stats_st_pops", h2c_byp_stats[1], 5);
        check("stats_drops", h2c_byp_stats[2], 1);
        check("stats_markers", h2c_byp_stats[3], 2);
`endif

        // ---- async reset with both FIFOs half full ----
        h2c_dsc_bypass = 1'b1;
        for (int i = 0; i < 4; i++) begin
            h2c_byp_out_st_mm = 1'b1;
            h2c_byp_out_dsc   = mk_mm(64'h4000 + 64'(i), 28'h8, 64'h5000, 1'b1);
            h2c_byp_out_vld   = 1'b1;
            @(negedge axi_aclk);
            h2c_byp_out_st_mm = 1'b0;
            h2c_byp_out_dsc   = mk_st(64'h6000 + 64'(i), 16'h8, 1'b1, 1'b1);
            @(negedge axi_aclk);
        end
        h2c_byp_out_vld = 1'b0;
        check("half_mm_level", mm_level, 4);
        check("half_st_level", st_level, 4);
        axi_aresetn = 1'b0;
        #1;
        check("arst_mm_vld", h2c_byp_in_mm_vld, 0);
        check("arst_st_vld", h2c_byp_in_st_vld, 0);
        check("arst_mm_level", mm_level, 0);
        check("arst_st_level", st_level, 0);
        check("arst_out_rdy", h2c_byp_out_rdy, 1);
        check("arst_mm_data", h2c_byp_in_mm, '0);
`ifdef DSC_BYP_STATS_EN
        check("arst_stats", h2c_byp_stats, '0);
`endif
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsc_byp_h2c_buf.md
Name: dsc_byp_h2c_buf

Overview:
Buffered, parametrised successor to the H2C descriptor-bypass loopback. It accepts descriptors from the QDMA H2C bypass-out interface and decodes them into MM or ST bypass-in descriptors. Each path has its own FIFO, so back-pressure on one path never stalls the other once a descriptor is accepted. It also registers marker responses and captures the marker request with each descriptor. It sits in the example design between the QDMA IP bypass-out and bypass-in ports.

Parameters:
DSC_W, 256, width of h2c_byp_out_dsc; must be at least 192.
QID_W, 11, queue-id width.
FIFO_DEPTH, 8, entries per path FIFO; power of 2, at least 2.
SDI_ON_EOP, 1, 1: MM sdi = dsc[94] (EOP); 0: MM sdi = 1.

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  asynchronous active-low reset
h2c_dsc_bypass  in  1  bypass enable
h2c_mm_marker_req / h2c_st_marker_req  in  1 each  marker request, captured into the next descriptor of that path
h2c_mm_marker_rsp / h2c_st_marker_rsp  out  1 each  registered one-cycle marker-response pulse
h2c_byp_out_dsc  in  DSC_W  raw descriptor
h2c_byp_out_mrkr_rsp, h2c_byp_out_st_mm, h2c_byp_out_error  in  1 each  (st_mm: 1 = MM, 0 = ST)
h2c_byp_out_qid  in  QID_W;  h2c_byp_out_func  in  8;  h2c_byp_out_cidx  in  16;  h2c_byp_out_port_id  in  3
h2c_byp_out_vld  in  1;  h2c_byp_out_rdy  out  1
h2c_byp_in_mm  out  mm_dsc_t  packed MM fields: radr, wadr, len, mrkr_req, sdi, qid, error, func, cidx, port_id, no_dma
h2c_byp_in_mm_vld  out  1;  h2c_byp_in_mm_rdy  in  1
h2c_byp_in_st  out  st_dsc_t  packed ST fields: addr, len, eop, sop, mrkr_req, sdi, qid, error, func, cidx, port_id, no_dma
h2c_byp_in_st_vld  out  1;  h2c_byp_in_st_rdy  in  1
mm_level, st_level  out  $clog2(FIFO_DEPTH)+1 each  FIFO occupancy

Behaviour:
- Accept condition: h2c_byp_out_vld & h2c_byp_out_rdy.
- Output rdy:
  - 1 when mrkr_rsp = 1.
  - 1 when h2c_dsc_bypass = 0; the descriptor is dropped.
  - Otherwise ~full of the target FIFO (st_mm selects). The full flag is registered and does not depend on the same-cycle pop.
- Marker response (mrkr_rsp = 1, accepted): never enqueued. The matching h2c_*_marker_rsp pulses high for exactly 1 cycle, on the cycle after acceptance.
- MM decode:
  - radr = dsc[63:0]; len = dsc[91:64]; wadr = dsc[191:128].
  - sdi = dsc[94] when SDI_ON_EOP = 1, else 1.
- ST decode:
  - len = dsc[47:32]; sop = dsc[48]; eop = dsc[49]; addr = dsc[127:64]; sdi = 1.
- Both paths: no_dma = 0. qid, error, func, cidx and port_id are copied from the sideband inputs.
- mrkr_req is sampled at enqueue and stored in the entry, so it travels with its descriptor.
- Enqueue path decodes into the struct, then writes the FIFO. Latency from accept to h2c_byp_in_*_vld is exactly 1 cycle.
- FIFO output: head is presented first-word-fall-through; vld = ~empty; pop on vld & rdy.
- Output stability: while vld = 1 and rdy = 0, data must stay stable.
- Pointers: QID-agnostic; wrap modulo FIFO_DEPTH using an extra wrap bit; level = wptr - rptr.
- Order: strict FIFO per path. No ordering is kept between paths.
- Bypass deasserted mid-stream: FIFO contents continue to drain; only new non-marker input is dropped.
- Push and pop in the same cycle: level unchanged. Full and popping: push still blocked that cycle.
- Reset (async assert, sync-released by the system):
  - Pointers and levels = 0; all vld = 0.
  - marker_rsp = 0; struct outputs = 0.
  - h2c_byp_out_rdy = 1 (bypass disabled until configured).

Optional Feature:
DSC_BYP_STATS_EN
- Defined: adds output h2c_byp_stats (4×32 bits) carrying saturating counters:
  - MM descriptors popped
  - ST descriptors popped
  - descriptors dropped while bypass off
  - marker responses seen
  Counters clear on reset and saturate at 0xFFFF_FFFF.
- Undefined: port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dsc_byp_pkg holds:
  - mm_dsc_t and st_dsc_t packed structs
  - descriptor bit-position localparams (MM_RADR_LSB, ST_SOP_BIT, and so on)
  - the decode functions
- One sub-module, dsc_byp_fifo, parametrised by data type/width and depth, instantiated twice.

Test Plan:
- Reset, bypass = 1, MM dsc with radr = 0x1000, len = 0x40, wadr = 0x2000, dsc[94] = 1, qid = 5 -> 1 cycle later mm_vld = 1 with those fields, sdi = 1, st_vld = 0.
- Hold mm_rdy = 0; send 9 MM dsc with FIFO_DEPTH = 8 -> out_rdy drops after the 8th accept, mm_level = 8. Interleaved ST dsc are still accepted and emitted. Releasing mm_rdy drains all 8 in order.
- mrkr_rsp = 1 with st_mm = 0, vld = 1 -> rdy = 1, st_marker_rsp pulses for exactly one cycle on the next cycle, FIFOs unchanged.
- h2c_st_marker_req = 1 during enqueue of ST dsc sop = 1, eop = 1, len = 0x100 -> that entry emits mrkr_req = 1; the next ST entry emits 0.
- Bypass = 0 with 3 entries queued -> entries drain, new non-marker dsc accepted and dropped (drop counter = 1 with DSC_BYP_STATS_EN).
- Assert axi_aresetn low with both FIFOs half full -> vld outputs 0 immediately, levels 0, rdy = 1.
